// File: rtl/neuron_buffer_sequencer_pkg.sv
// neuron_buffer_sequencer_pkg: shared FSM encoding and default address width
package neuron_buffer_sequencer_pkg;
    localparam int A_DEFAULT = 7;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_SWAP} state_t;
endpackage

// File: rtl/neuron_buffer_sequencer_counter.sv
// neuron_buffer_sequencer_counter: up-counter with synchronous clear and enable
module neuron_buffer_sequencer_counter
    import neuron_buffer_sequencer_pkg::*;
#(
    parameter int W = A_DEFAULT + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) q <= '0;
        else if (en) q <= q + W'(1);
    end
endmodule

// File: rtl/neuron_buffer_sequencer.sv
// neuron_buffer_sequencer: per-layer read/write sequencing and role swap for the N1/N2 ping-pong buffers
module neuron_buffer_sequencer
    import neuron_buffer_sequencer_pkg::*;
#(
    parameter int A     = A_DEFAULT,
    parameter int depth = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [A:0]   cfgReadWords,
    input  logic [A:0]   cfgWriteWords,
    input  logic         cfgPool,
    input  logic         rdReady,
    input  logic         wrValid,
    output logic         readBufferSelect,
    output logic         doPooling,
    output logic [A-1:0] readBuffAddress,
    output logic [A-1:0] writeBuffAddress,
    output logic         nRWrite,
    output logic         nWWrite,
    output logic         rdValid,
    output logic         busy,
    output logic         layerDone,
    output logic         wrOverflow
);
    if (depth < 0) begin : g_depth_check
        $error("depth must be non-negative");
    end

    state_t     state, nxt;
    logic [A:0] cfg_rd, cfg_wr, rd_cnt, wr_cnt;
    logic       pool, rbs, ovf, launch, active, rd_last, wr_done;

    assign launch  = state == S_IDLE && start;
    assign active  = state == S_READ || state == S_DRAIN;
    assign rd_last = (rd_cnt + {{A{1'b0}}, 1'b1}) == cfg_rd;
    assign wr_done = (wr_cnt + {{A{1'b0}}, nWWrite}) == cfg_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = start ? (cfgReadWords != '0 ? S_READ : S_DRAIN) : S_IDLE;
            S_READ:  nxt = rdReady && rd_last ? S_DRAIN : S_READ;
            S_DRAIN: nxt = wr_done ? S_SWAP : S_DRAIN;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdValid   = state == S_READ;
        busy      = state != S_IDLE;
        layerDone = state == S_SWAP;
        nWWrite   = active && wrValid && (wr_cnt < cfg_wr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_rd <= '0;
            cfg_wr <= '0;
            pool   <= 1'b0;
            rbs    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (launch) begin
                cfg_rd <= cfgReadWords;
                cfg_wr <= cfgWriteWords;
                pool   <= cfgPool;
                ovf    <= 1'b0;
            end else if (active && wrValid && !nWWrite) begin
                ovf <= 1'b1;
            end
            if (state == S_SWAP) rbs <= !rbs;
        end
    end

    neuron_buffer_sequencer_counter #(.W(A + 1)) u_rd_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (launch),
        .en   (rdValid && rdReady),
        .q    (rd_cnt)
    );

    neuron_buffer_sequencer_counter #(.W(A + 1)) u_wr_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (launch),
        .en   (nWWrite),
        .q    (wr_cnt)
    );

    assign readBufferSelect = rbs;
    assign doPooling        = pool;
    assign readBuffAddress  = rd_cnt[A-1:0];
    assign writeBuffAddress = wr_cnt[A-1:0];
    assign nRWrite          = 1'b0;
    assign wrOverflow       = ovf;
endmodule

// File: tb/tb_neuron_buffer_sequencer.sv
// tb_neuron_buffer_sequencer: scenario tasks plus address scoreboard for neuron_buffer_sequencer
module tb_neuron_buffer_sequencer;
    localparam int A = 7;
    localparam int W = A + 1;

    logic         clk = 1'b0;
    logic         rst_n, start, cfgPool, rdReady, wrValid;
    logic [A:0]   cfgReadWords, cfgWriteWords;
    logic         readBufferSelect, doPooling, nRWrite, nWWrite, rdValid, busy, layerDone, wrOverflow;
    logic [A-1:0] readBuffAddress, writeBuffAddress;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_exp[$];
    int   wr_exp[$];
    logic exp_rbs;

    always #5 clk = ~clk;

    neuron_buffer_sequencer #(.A(A), .depth(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfgReadWords    (cfgReadWords),
        .cfgWriteWords   (cfgWriteWords),
        .cfgPool         (cfgPool),
        .rdReady         (rdReady),
        .wrValid         (wrValid),
        .readBufferSelect(readBufferSelect),
        .doPooling       (doPooling),
        .readBuffAddress (readBuffAddress),
        .writeBuffAddress(writeBuffAddress),
        .nRWrite         (nRWrite),
        .nWWrite         (nWWrite),
        .rdValid         (rdValid),
        .busy            (busy),
        .layerDone       (layerDone),
        .wrOverflow      (wrOverflow)
    );

    always @(negedge clk) begin
        int e;
        #2;
        if (rst_n === 1'b1) begin
            if (rdValid === 1'b1 && rdReady === 1'b1) begin
                n_cmp++;
                if (rd_exp.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_scoreboard: unexpected read handshake at address %0d", readBuffAddress);
                end else begin
                    e = rd_exp.pop_front();
                    if (int'(readBuffAddress) != e) begin
                        n_bad++;
                        $display("FAIL rd_scoreboard: address %0d, expected %0d", readBuffAddress, e);
                    end
                end
            end
            if (nWWrite === 1'b1) begin
                n_cmp++;
                if (wr_exp.size() == 0) begin
                    n_bad++;
                    $display("FAIL wr_scoreboard: unexpected write strobe at address %0d", writeBuffAddress);
                end else begin
                    e = wr_exp.pop_front();
                    if (int'(writeBuffAddress) != e) begin
                        n_bad++;
                        $display("FAIL wr_scoreboard: address %0d, expected %0d", writeBuffAddress, e);
                    end
                end
            end
            n_cmp++;
            if (nRWrite !== 1'b0) begin
                n_bad++;
                $display("FAIL nRWrite: got %b, expected 0", nRWrite);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        wrValid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        rd_exp.delete();
        wr_exp.delete();
        exp_rbs = 1'b0;
    endtask

    task automatic begin_layer(input int rd, input int wr, input logic pl);
        cyc();
        start = 1'b1;
        cfgReadWords = W'(rd);
        cfgWriteWords = W'(wr);
        cfgPool = pl;
        for (int i = 0; i < rd; i++) rd_exp.push_back(i);
        for (int i = 0; i < wr; i++) wr_exp.push_back(i);
        cyc();
        start = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (rd_exp.size() != 0 || wr_exp.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drained: %0d reads and %0d writes outstanding, expected 0 and 0", name, rd_exp.size(), wr_exp.size());
        end
    endtask

    task automatic run_layer(input int rd, input int wr);
        int  i;
        bit  found;
        begin_layer(rd, wr, 1'b0);
        rdReady = 1'b1;
        wrValid = wr > 0;
        #1;
        n_cmp++;
        if ({readBuffAddress, writeBuffAddress} !== '0) begin
            n_bad++;
            $display("FAIL layer_restart: addresses %0d/%0d, expected 0/0", readBuffAddress, writeBuffAddress);
        end
        i = 0;
        found = 0;
        while (!found && i < rd + wr + 8) begin
            if (layerDone === 1'b1) found = 1;
            else begin
                cyc();
                i++;
                wrValid = i < wr;
                #1;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL layer_timeout: layerDone=0 after %0d cycles, expected 1", i);
        end
        wrValid = 1'b0;
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if ({readBufferSelect, busy} !== {exp_rbs, 1'b0}) begin
            n_bad++;
            $display("FAIL layer_end: rbs/busy=%b, expected %b", {readBufferSelect, busy}, {exp_rbs, 1'b0});
        end
        check_drained("layer");
    endtask

    task automatic test_reset();
        logic [21:0] v;
        rst_n = 1'b0;
        start = 1'b0;
        cfgPool = 1'b0;
        rdReady = 1'b0;
        wrValid = 1'b0;
        cfgReadWords = '0;
        cfgWriteWords = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_rbs = 1'b0;
        repeat (5) cyc();
        #1;
        v = {readBufferSelect, doPooling, readBuffAddress, writeBuffAddress, nRWrite, nWWrite, rdValid, busy, layerDone, wrOverflow};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 000000", v);
        end
        n_cmp++;
        if (readBufferSelect !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rbs: got %b, expected 0", readBufferSelect);
        end
    endtask

    task automatic test_basic();
        logic [16:0] v;
        begin_layer(4, 4, 1'b1);
        rdReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrValid = 1'b1;
            #1;
            v = {rdValid, readBuffAddress, nWWrite, writeBuffAddress, doPooling};
            n_cmp++;
            if (v !== {1'b1, 7'(i), 1'b1, 7'(i), 1'b1}) begin
                n_bad++;
                $display("FAIL basic_cycle%0d: got %h, expected %h", i, v, {1'b1, 7'(i), 1'b1, 7'(i), 1'b1});
            end
            cyc();
        end
        wrValid = 1'b0;
        #1;
        n_cmp++;
        if ({rdValid, busy, layerDone} !== 3'b010) begin
            n_bad++;
            $display("FAIL basic_drain: rdValid/busy/layerDone=%b, expected 010", {rdValid, busy, layerDone});
        end
        cyc();
        #1;
        n_cmp++;
        if (layerDone !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_layerdone: got %b, expected 1", layerDone);
        end
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if ({readBufferSelect, busy, layerDone} !== {exp_rbs, 2'b00}) begin
            n_bad++;
            $display("FAIL basic_swap: rbs/busy/layerDone=%b, expected %b", {readBufferSelect, busy, layerDone}, {exp_rbs, 2'b00});
        end
        check_drained("basic");
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_layer(2, 2);
        run_layer(3, 3);
    endtask

    task automatic test_stall();
        int   ea[8] = '{0, 1, 2, 2, 2, 2, 3, 4};
        logic rr[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic [10:0] v;
        begin_layer(5, 5, 1'b0);
        wrValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdReady = rr[i];
            #1;
            n_cmp++;
            if ({rdValid, readBuffAddress} !== {1'b1, 7'(ea[i])}) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: rdValid/addr=%h, expected %h", i, {rdValid, readBuffAddress}, {1'b1, 7'(ea[i])});
            end
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            wrValid = 1'b1;
            #1;
            v = {rdValid, busy, nWWrite, writeBuffAddress, layerDone};
            n_cmp++;
            if (v !== {3'b011, 7'(i), 1'b0}) begin
                n_bad++;
                $display("FAIL stall_drain%0d: got %h, expected %h", i, v, {3'b011, 7'(i), 1'b0});
            end
            cyc();
        end
        wrValid = 1'b0;
        #1;
        n_cmp++;
        if (layerDone !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_last_write_swap: layerDone=%b, expected 1", layerDone);
        end
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if (readBufferSelect !== exp_rbs) begin
            n_bad++;
            $display("FAIL stall_rbs: got %b, expected %b", readBufferSelect, exp_rbs);
        end
        check_drained("stall");
    endtask

    task automatic test_overflow();
        begin_layer(4, 2, 1'b0);
        rdReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrValid = 1'b1;
            #1;
            n_cmp++;
            if (nWWrite !== (i < 2)) begin
                n_bad++;
                $display("FAIL overflow_strobe%0d: nWWrite=%b, expected %b", i, nWWrite, i < 2);
            end
            cyc();
        end
        wrValid = 1'b0;
        #1;
        n_cmp++;
        if (wrOverflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_flag: got %b, expected 1", wrOverflow);
        end
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({layerDone, wrOverflow} !== 2'b11) begin
            n_bad++;
            $display("FAIL overflow_swap: layerDone/wrOverflow=%b, expected 11", {layerDone, wrOverflow});
        end
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if ({wrOverflow, busy, readBufferSelect} !== {2'b10, exp_rbs}) begin
            n_bad++;
            $display("FAIL overflow_sticky: ovf/busy/rbs=%b, expected %b", {wrOverflow, busy, readBufferSelect}, {2'b10, exp_rbs});
        end
        check_drained("overflow");
    endtask

    task automatic test_zero();
        begin_layer(0, 0, 1'b0);
        rdReady = 1'b1;
        wrValid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rdValid, layerDone, wrOverflow} !== 4'b1000) begin
            n_bad++;
            $display("FAIL zero_drain: busy/rdValid/layerDone/ovf=%b, expected 1000", {busy, rdValid, layerDone, wrOverflow});
        end
        cyc();
        wrValid = 1'b1;
        #1;
        n_cmp++;
        if ({busy, layerDone, nWWrite} !== 3'b110) begin
            n_bad++;
            $display("FAIL zero_swap: busy/layerDone/nWWrite=%b, expected 110", {busy, layerDone, nWWrite});
        end
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if ({busy, layerDone, wrOverflow, nWWrite, readBufferSelect} !== {4'b0000, exp_rbs}) begin
            n_bad++;
            $display("FAIL zero_idle: busy/layerDone/ovf/nWWrite/rbs=%b, expected %b", {busy, layerDone, wrOverflow, nWWrite, readBufferSelect}, {4'b0000, exp_rbs});
        end
        wrValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [18:0] v;
        if (exp_rbs == 1'b0) run_layer(1, 1);
        begin_layer(4, 4, 1'b1);
        rdReady = 1'b1;
        wrValid = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        exp_rbs = 1'b0;
        rd_exp.delete();
        wr_exp.delete();
        #1;
        v = {busy, readBufferSelect, rdValid, doPooling, nWWrite, readBuffAddress, writeBuffAddress};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h, expected 00000", v);
        end
        wrValid = 1'b0;
    endtask

    task automatic test_start_busy();
        begin_layer(3, 3, 1'b0);
        rdReady = 1'b1;
        wrValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            cfgReadWords = W'(1);
            cfgWriteWords = W'(0);
            cfgPool = 1'b1;
            #1;
            n_cmp++;
            if ({doPooling, rdValid, readBuffAddress} !== {2'b01, 7'(i)}) begin
                n_bad++;
                $display("FAIL start_busy_read%0d: got %h, expected %h", i, {doPooling, rdValid, readBuffAddress}, {2'b01, 7'(i)});
            end
            cyc();
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wrValid = 1'b1;
            #1;
            n_cmp++;
            if ({busy, nWWrite, writeBuffAddress} !== {2'b11, 7'(i)}) begin
                n_bad++;
                $display("FAIL start_busy_write%0d: got %h, expected %h", i, {busy, nWWrite, writeBuffAddress}, {2'b11, 7'(i)});
            end
            cyc();
        end
        wrValid = 1'b0;
        #1;
        n_cmp++;
        if (layerDone !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy_done: layerDone=%b, expected 1", layerDone);
        end
        cyc();
        exp_rbs = ~exp_rbs;
        #1;
        n_cmp++;
        if ({busy, readBufferSelect} !== {1'b0, exp_rbs}) begin
            n_bad++;
            $display("FAIL start_busy_end: busy/rbs=%b, expected %b", {busy, readBufferSelect}, {1'b0, exp_rbs});
        end
        check_drained("start_busy");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_zero();
        test_reset_mid();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
